data_mem_lsu: RTL

Parametrised data-memory load/store unit for the single-cycle/multi-cycle RISC-V core. It replaces the word-only data memory and adds byte and half-word loads and stores, signed/unsigned load extension, misalignment detection and a valid/ready request handshake. The memory is an internal synchronous-read RAM. Sub-word stores are performed as internal read-modify-write sequences sequenced by a small FSM.

---
 rtl/data_mem_lsu_if.sv | 38 +++
 rtl/data_mem_lsu.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu_if.sv
// -----------------------------------------------------------------------------
// data_mem_lsu_if
// Request/response bus between the core and the data-memory load/store unit.
//   req_valid    : request present (master -> slave)
//   req_ready    : unit can accept a request (slave -> master)
//   req_we       : 1 = store, 0 = load
//   req_mode     : 00 word, 01 half-word, 1X byte
//   req_unsigned : zero-extend loads when 1, sign-extend when 0
//   req_addr     : little-endian byte address, ADDR_W+2 bits
//   req_wdata    : store data (half uses [15:0], byte uses [7:0])
//   resp_valid   : one-cycle completion pulse
//   resp_rdata   : load result, 0 for stores and errors
//   resp_err     : misaligned access, qualified by resp_valid
// -----------------------------------------------------------------------------
interface data_mem_lsu_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_mode;
    logic              req_unsigned;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_mode, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_mode, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// -----------------------------------------------------------------------------
// data_mem_lsu
// Data-memory load/store unit with an internal synchronous-read RAM of
// 2^ADDR_W 32-bit words. Supports word, half-word and byte accesses with
// signed/unsigned load extension and misalignment detection. Sub-word stores
// are done as an internal read-modify-write (IDLE read, RD merge + write).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : data_mem_lsu_if slave modport (request/response handshake)
// -----------------------------------------------------------------------------
module data_mem_lsu #(
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    data_mem_lsu_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        r_state;
    logic              r_we;
    logic              r_unsigned;
    logic [1:0]        r_mode;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic [31:0]       r_rd_word;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_misaligned;
    logic              w_word_store;
    logic [4:0]        w_byte_sh;
    logic [4:0]        w_half_sh;
    logic [7:0]        w_lane8;
    logic [15:0]       w_lane16;
    logic [31:0]       w_merged;
    logic [31:0]       w_load;
    logic              w_mem_we;
    logic              w_mem_re;
    logic [ADDR_W-1:0] w_mem_idx;
    logic [31:0]       w_mem_wdata;

    // Gating with rst_n makes requests presented during reset invisible.
    assign bus.req_ready  = (r_state == ST_IDLE) && rst_n;
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;

    assign w_accept     = bus.req_valid && bus.req_ready;
    assign w_misaligned = ((bus.req_mode == 2'b01) && bus.req_addr[0]) ||
                          ((bus.req_mode == 2'b00) && (bus.req_addr[1:0] != 2'b00));
    assign w_word_store = bus.req_we && (bus.req_mode == 2'b00);

    assign w_byte_sh = {r_addr[1:0], 3'b000};
    assign w_half_sh = {r_addr[1], 4'b0000};
    assign w_lane8   = r_rd_word[w_byte_sh +: 8];
    assign w_lane16  = r_rd_word[w_half_sh +: 16];

    // Lane merge for sub-word stores and lane extraction/extension for loads,
    // both working on the word read at the acceptance edge.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_merged = r_rd_word;
        w_load   = r_rd_word;
        if (r_mode[1]) begin
            w_merged[w_byte_sh +: 8] = r_wdata[7:0];
            w_load = {{24{~r_unsigned & w_lane8[7]}}, w_lane8};
        end else if (r_mode[0]) begin
            w_merged[w_half_sh +: 16] = r_wdata[15:0];
            w_load = {{16{~r_unsigned & w_lane16[15]}}, w_lane16};
        end
    end

    // RAM port control: acceptance uses the live request address, the RD
    // write-back uses the latched one. A reset drops r_state to IDLE
    // asynchronously, so an abandoned RMW never writes.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_idx   = r_addr[ADDR_W+1:2];
        w_mem_wdata = w_merged;
        if (w_accept && !w_misaligned) begin
            w_mem_idx = bus.req_addr[ADDR_W+1:2];
            if (w_word_store) begin
                w_mem_we    = 1'b1;
                w_mem_wdata = bus.req_wdata;
            end else begin
                w_mem_re = 1'b1;
            end
        end else if ((r_state == ST_RD) && r_we) begin
            w_mem_we = 1'b1;
        end
    end

    // NOTE: the RAM array and its read register carry no reset; memories are
    // not cleared and contents stay undefined until written.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
        if (w_mem_re) begin
            r_rd_word <= r_mem[w_mem_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_mode       <= 2'b00;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we       <= bus.req_we;
                        r_unsigned <= bus.req_unsigned;
                        r_mode     <= bus.req_mode;
                        r_addr     <= bus.req_addr;
                        r_wdata    <= bus.req_wdata;
                        if (w_misaligned || w_word_store) begin
                            r_state      <= ST_RESP;
                            r_resp_err   <= w_misaligned;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= r_we ? 32'h0 : w_load;
                    r_state      <= ST_RESP;
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
